// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM encoding, raw frame width and frame-length helper.
// The Rx_Remap stage imports the same package so both ends agree on the encoding.
package uart_pkg;

  localparam int FRAME_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2
  } uart_state_e;

  // Bits sampled after the start bit (data + optional parity + stop) for a {pen, eight} select
  function automatic logic [3:0] frame_len(input logic [1:0] fmt_sel);
    frame_len = 4'd8 + {3'b000, fmt_sel[0]} + {3'b000, fmt_sel[1]};
  endfunction

endpackage

// File: rtl/uart_rx_engine_rx_sync.sv
// Parameterized multi-flop synchronizer for the asynchronous rx pin.
// Every stage resets to the idle line level (1).
module rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift chain; sync_r[0] is the metastability-exposed stage
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive front end: start-bit qualification, mid-bit sampling and a
// left-justified 10-bit raw frame register handed to Rx_Remap with its format select.
module uart_rx_engine
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int K_WIDTH     = 19
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               rx,
  input  logic [K_WIDTH-1:0] baud_k,
  input  logic               eight,
  input  logic               pen,
  output logic [FRAME_W-1:0] data_out,
  output logic [1:0]         sel,
  output logic               rx_done,
  output logic               busy
);

  logic                rx_s;
  uart_state_e         state_r, state_nxt_s;
  logic [K_WIDTH-1:0]  timer_r, timer_nxt_s;
  logic [3:0]          bit_cnt_r, bit_cnt_nxt_s;
  logic [FRAME_W-1:0]  data_r, data_nxt_s;
  logic [1:0]          sel_r, sel_nxt_s;
  logic                done_r, done_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic [K_WIDTH-1:0]  half_s;
  logic [K_WIDTH-1:0]  last_s;
  logic [3:0]          cnt_inc_s;

  rx_sync #(
    .STAGES (SYNC_STAGES)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  assign half_s    = baud_k >> 1;
  assign last_s    = baud_k - {{(K_WIDTH-1){1'b0}}, 1'b1};
  assign cnt_inc_s = bit_cnt_r + 4'd1;

  // State and datapath registers; every output is taken straight from a flop
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      timer_r   <= {K_WIDTH{1'b0}};
      bit_cnt_r <= 4'd0;
      data_r    <= {FRAME_W{1'b0}};
      sel_r     <= 2'b00;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      timer_r   <= timer_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      data_r    <= data_nxt_s;
      sel_r     <= sel_nxt_s;
      done_r    <= done_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

  // Next-state and next-datapath decode for the receive FSM
  always_comb begin
    state_nxt_s   = state_r;
    timer_nxt_s   = timer_r;
    bit_cnt_nxt_s = bit_cnt_r;
    data_nxt_s    = data_r;
    sel_nxt_s     = sel_r;
    done_nxt_s    = 1'b0;
    busy_nxt_s    = busy_r;

    case (state_r)
      ST_IDLE: begin
        if (!rx_s) begin
          timer_nxt_s = {K_WIDTH{1'b0}};
          state_nxt_s = ST_START;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end

      ST_START: begin
        if (timer_r == half_s) begin
          if (!rx_s) begin
            // Format is frozen here; later changes on eight/pen wait for the next frame
            sel_nxt_s     = {pen, eight};
            timer_nxt_s   = {K_WIDTH{1'b0}};
            bit_cnt_nxt_s = 4'd0;
            busy_nxt_s    = 1'b1;
            state_nxt_s   = ST_DATA;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          timer_nxt_s = timer_r + {{(K_WIDTH-1){1'b0}}, 1'b1};
        end
      end

      ST_DATA: begin
        if (timer_r == last_s) begin
          data_nxt_s    = {rx_s, data_r[FRAME_W-1:1]};
          bit_cnt_nxt_s = cnt_inc_s;
          timer_nxt_s   = {K_WIDTH{1'b0}};
          if (cnt_inc_s == frame_len(sel_r)) begin
            // Straight back to IDLE so a start edge half a bit later is still caught
            done_nxt_s  = 1'b1;
            busy_nxt_s  = 1'b0;
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          timer_nxt_s = timer_r + {{(K_WIDTH-1){1'b0}}, 1'b1};
        end
      end

      default: begin
        state_nxt_s = ST_IDLE;
        busy_nxt_s  = 1'b0;
      end
    endcase
  end

  assign data_out = data_r;
  assign sel      = sel_r;
  assign rx_done  = done_r;
  assign busy     = busy_r;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Directed scoreboard bench for uart_rx_engine at baud_k = 16: frames are modelled
// as they are driven, and each rx_done capture is compared against the queue.
module tb_uart_rx_engine;

  localparam int BAUD = 16;

  logic        clk;
  logic        reset;
  logic        rx;
  logic [18:0] baud_k;
  logic        eight;
  logic        pen;
  logic [9:0]  data_out;
  logic [1:0]  sel;
  logic        rx_done;
  logic        busy;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fail_cnt  = 0;

  logic [9:0]  exp_reg;
  logic [11:0] exp_q[$];
  logic [11:0] obs_data [0:63];
  int          obs_cnt   = 0;
  int          rd_ptr    = 0;
  int          exp_total = 0;
  int          busy_cyc  = 0;

  uart_rx_engine dut (
    .clk      (clk),
    .reset    (reset),
    .rx       (rx),
    .baud_k   (baud_k),
    .eight    (eight),
    .pen      (pen),
    .data_out (data_out),
    .sel      (sel),
    .rx_done  (rx_done),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture each completed frame and count busy cycles, sampled on the falling edge
  always @(negedge clk) begin
    if (rx_done && obs_cnt < 64) begin
      obs_data[obs_cnt] <= {data_out, sel};
      obs_cnt <= obs_cnt + 1;
    end
    if (busy) busy_cyc <= busy_cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BAUD) @(negedge clk);
  endtask

  // Start bit, then n frame bits LSB first; eight switches to eight_mid after the start bit
  task automatic send_frame(input logic [9:0] bits, input int n, input logic [1:0] fmt,
                            input logic eight_mid);
    pen   = fmt[1];
    eight = fmt[0];
    drive_bit(1'b0);
    eight = eight_mid;
    for (int i = 0; i < n; i++) begin
      drive_bit(bits[i]);
      exp_reg = {bits[i], exp_reg[9:1]};
    end
    exp_q.push_back({exp_reg, fmt});
    exp_total++;
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * BAUD) @(negedge clk);
  endtask

  // Compare every newly captured frame with the scoreboard head
  task automatic drain(input string tag);
    logic [11:0] e;
    check({tag, "_count"}, obs_cnt, exp_total);
    while (rd_ptr < obs_cnt) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({tag, "_data"}, {22'd0, obs_data[rd_ptr][11:2]}, {22'd0, e[11:2]});
        check({tag, "_sel"},  {30'd0, obs_data[rd_ptr][1:0]},  {30'd0, e[1:0]});
      end else begin
        check({tag, "_unexpected"}, 32'd1, 32'd0);
      end
      rd_ptr++;
    end
  endtask

  int busy_before;

  initial begin
    reset   = 1'b1;
    rx      = 1'b1;
    baud_k  = 19'd16;
    eight   = 1'b0;
    pen     = 1'b0;
    exp_reg = 10'h000;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_data", {22'd0, data_out}, 32'h000);
    check("rst_sel",  {30'd0, sel},      32'd0);
    check("rst_done", {31'd0, rx_done},  32'd0);
    check("rst_busy", {31'd0, busy},     32'd0);
    idle_bits(1);

    // 7N1, data 0x0A
    send_frame(10'h08A, 8, 2'b00, 1'b0);
    idle_bits(2);
    drain("f7n1");
    check("f7n1_const", {22'd0, data_out}, 32'h228);

    // 8E1, data 0xA5, parity 0; busy spans exactly 10 bit times
    busy_before = busy_cyc;
    send_frame(10'h2A5, 10, 2'b11, 1'b1);
    idle_bits(2);
    drain("f8e1");
    check("f8e1_busy", busy_cyc - busy_before, 10 * BAUD);
    check("f8e1_const", {22'd0, data_out}, 32'h2A5);

    // False start: 6 clocks low
    rx = 1'b0;
    repeat (6) @(negedge clk);
    idle_bits(2);
    drain("false_start");
    check("false_data", {22'd0, data_out}, {22'd0, exp_reg});
    check("false_busy", {31'd0, busy}, 32'd0);

    // Two 8N1 frames back-to-back
    send_frame(10'h155, 9, 2'b01, 1'b1);
    send_frame(10'h1C3, 9, 2'b01, 1'b1);
    idle_bits(2);
    drain("b2b");

    // Reset around the 4th data sample of an 8N1 frame carrying 0x3C
    eight = 1'b1;
    pen   = 1'b0;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b1);
    rx = 1'b1;
    repeat (BAUD / 2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mrst_data", {22'd0, data_out}, 32'h000);
    check("mrst_busy", {31'd0, busy},     32'd0);
    check("mrst_sel",  {30'd0, sel},      32'd0);
    check("mrst_done", {31'd0, rx_done},  32'd0);
    reset   = 1'b0;
    exp_reg = 10'h000;
    idle_bits(3);
    drain("mrst_nostrobe");
    send_frame(10'h196, 9, 2'b01, 1'b1);
    idle_bits(2);
    drain("after_rst");

    // Mid-frame eight toggles are ignored until the next frame
    send_frame(10'h0B3, 8, 2'b00, 1'b1);
    idle_bits(2);
    drain("tog_7to8");
    send_frame(10'h16E, 9, 2'b01, 1'b0);
    idle_bits(2);
    drain("tog_8to7");

    check("queue_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
